cr_osf_ob_drain: RTL and testbench

CR_OSF_OB_DRAIN -- requirements
Module: cr_osf_ob_drain

---
 rtl/cr_osf_ob_drain.sv | 231 +++++++++++++++++++++++
 tb/tb_cr_osf_ob_drain.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_osf_ob_drain.sv
// ---------------------------------------------------------------------------
// cr_osf_ob_drain -- OSF output-buffer drain stage.
//
// Pops words from a show-ahead output FIFO into a 2-entry skid buffer and
// presents them on an AXI4-Stream style egress port. Tracks frame framing
// (sot/eot carried in tuser[0]/tuser[1]) with a two-state FSM, flags framing
// errors stickily, and can park the stream at a frame boundary (ob_hold).
//
// Ports:
//   clk            in   block clock, rising edge
//   rst_n          in   synchronous active-low reset
//   ob_fifo_rdata  in   head word of the output FIFO (show-ahead)
//   ob_fifo_empty  in   output FIFO empty
//   ob_fifo_rd     out  pop of the FIFO head word (no path from ob_out_tready)
//   ob_out         out  egress word, valid while ob_out_tvalid=1
//   ob_out_tvalid  out  egress valid
//   ob_out_tready  in   egress ready
//   ob_hold        in   stall egress at the next frame boundary
//   ob_err_clr     in   clear sticky framing errors
//   ob_sot_err     out  sticky: sot seen inside a frame
//   ob_nosot_err   out  sticky: frame started without sot
//   ob_frame_cnt   out  frames egressed (stats build only, else 0)
//   ob_beat_cnt    out  beats egressed (stats build only, else 0)
//
// Build option: define CR_OSF_OB_STATS_EN to include the frame/beat
// counters; when undefined both counter outputs are constant 0.
// ---------------------------------------------------------------------------
package cr_osf_ob_drain_pkg;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic [7:0]  tuser;
    } axi4s_dp_bus_t;

    typedef enum logic {
        OB_IDLE  = 1'b0,
        OB_FRAME = 1'b1
    } ob_state_e;

endpackage

module cr_osf_ob_drain
    import cr_osf_ob_drain_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  axi4s_dp_bus_t ob_fifo_rdata,
    input  logic          ob_fifo_empty,
    output logic          ob_fifo_rd,
    output axi4s_dp_bus_t ob_out,
    output logic          ob_out_tvalid,
    input  logic          ob_out_tready,
    input  logic          ob_hold,
    input  logic          ob_err_clr,
    output logic          ob_sot_err,
    output logic          ob_nosot_err,
    output logic [31:0]   ob_frame_cnt,
    output logic [31:0]   ob_beat_cnt
);

    ob_state_e     state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    axi4s_dp_bus_t head_q, head_d;
    axi4s_dp_bus_t tail_q, tail_d;
    logic          sot_err_q, sot_err_d;
    logic          nosot_err_q, nosot_err_d;

    logic pop;
    logic accept;
    logic pop_sot;
    logic pop_eot;
    logic hold_block;
    logic sot_err_set;
    logic nosot_err_set;

    assign pop_sot = ob_fifo_rdata.tuser[0];
    assign pop_eot = ob_fifo_rdata.tuser[1];

    // Pop decision depends only on registered occupancy/state, never on
    // ob_out_tready: the second skid entry absorbs the beat in flight.
    // rst_n is folded in so no word leaves the FIFO while in reset.
    assign pop    = rst_n && !ob_fifo_empty && (cnt_q != 2'd2) && !hold_block;
    assign accept = ob_out_tvalid && ob_out_tready;

    assign ob_fifo_rd    = pop;
    assign ob_out        = head_q;
    assign ob_out_tvalid = (cnt_q != 2'd0);
    assign ob_sot_err    = sot_err_q;
    assign ob_nosot_err  = nosot_err_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state (advances on popped words) --------
    always_comb begin
        state_d = state_q;
        if (pop) begin
            case (state_q)
                OB_IDLE:  if (!pop_eot) state_d = OB_FRAME;
                OB_FRAME: if (pop_eot)  state_d = OB_IDLE;
                default:  state_d = OB_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        hold_block    = 1'b0;
        sot_err_set   = 1'b0;
        nosot_err_set = 1'b0;
        case (state_q)
            OB_IDLE: begin
                // Hold only parks the stream between frames.
                hold_block    = ob_hold;
                nosot_err_set = pop && !pop_sot;
            end
            OB_FRAME: begin
                sot_err_set = pop && pop_sot;
            end
            default: begin
                hold_block = 1'b0;
            end
        endcase
    end

    // ---------------- skid buffer ----------------
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (accept) begin
            // Head leaves: refill from the tail if present, else from the
            // word popped this cycle (keeps arrival order).
            if (cnt_q == 2'd2) begin
                head_d = tail_q;
            end else if (pop) begin
                head_d = ob_fifo_rdata;
            end
            if (!pop) begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (pop) begin
            if (cnt_q == 2'd0) begin
                head_d = ob_fifo_rdata;
            end else begin
                tail_d = ob_fifo_rdata;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // ---------------- sticky errors (set beats clear) ----------------
    always_comb begin
        sot_err_d   = sot_err_q;
        nosot_err_d = nosot_err_q;
        if (ob_err_clr) begin
            sot_err_d   = 1'b0;
            nosot_err_d = 1'b0;
        end
        if (sot_err_set) begin
            sot_err_d = 1'b1;
        end
        if (nosot_err_set) begin
            nosot_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sot_err_q   <= 1'b0;
            nosot_err_q <= 1'b0;
        end else begin
            sot_err_q   <= sot_err_d;
            nosot_err_q <= nosot_err_d;
        end
    end

    // ---------------- statistics ----------------
`ifdef CR_OSF_OB_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (head_q.tuser[1]) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 32'd0;
            beat_cnt_q  <= 32'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign ob_frame_cnt = frame_cnt_q;
    assign ob_beat_cnt  = beat_cnt_q;
`else
    assign ob_frame_cnt = 32'd0;
    assign ob_beat_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_cr_osf_ob_drain.sv
// ---------------------------------------------------------------------------
// Testbench for cr_osf_ob_drain: a queue-based FIFO model feeds the DUT, a
// scoreboard queue holds every word pushed and is compared in order against
// each accepted egress beat, and directed steps check latency, back-pressure,
// hold, framing errors, counters and reset behaviour.
// ---------------------------------------------------------------------------
module tb_cr_osf_ob_drain;
    import cr_osf_ob_drain_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    axi4s_dp_bus_t ob_fifo_rdata;
    logic          ob_fifo_empty;
    logic          ob_fifo_rd;
    axi4s_dp_bus_t ob_out;
    logic          ob_out_tvalid;
    logic          ob_out_tready;
    logic          ob_hold;
    logic          ob_err_clr;
    logic          ob_sot_err;
    logic          ob_nosot_err;
    logic [31:0]   ob_frame_cnt;
    logic [31:0]   ob_beat_cnt;

    cr_osf_ob_drain dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ob_fifo_rdata (ob_fifo_rdata),
        .ob_fifo_empty (ob_fifo_empty),
        .ob_fifo_rd    (ob_fifo_rd),
        .ob_out        (ob_out),
        .ob_out_tvalid (ob_out_tvalid),
        .ob_out_tready (ob_out_tready),
        .ob_hold       (ob_hold),
        .ob_err_clr    (ob_err_clr),
        .ob_sot_err    (ob_sot_err),
        .ob_nosot_err  (ob_nosot_err),
        .ob_frame_cnt  (ob_frame_cnt),
        .ob_beat_cnt   (ob_beat_cnt)
    );

    always #5 clk = ~clk;

    axi4s_dp_bus_t fifo_q[$];
    axi4s_dp_bus_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pop_cnt = 0;
    int   acc_cnt = 0;
    logic pop_pend = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic axi4s_dp_bus_t mk(input int id, input logic sot, input logic eot);
        axi4s_dp_bus_t w;
        w.tdata = {32'hC0DE_0000, id[31:0]} ^ {id[31:0], 32'h5A5A_0000};
        w.tkeep = 8'hFF;
        w.tlast = eot;
        w.tuser = {6'b0, eot, sot};
        return w;
    endfunction

    task automatic refresh_head();
        if (fifo_q.size() != 0) begin
            ob_fifo_rdata = fifo_q[0];
            ob_fifo_empty = 1'b0;
        end else begin
            ob_fifo_rdata = '0;
            ob_fifo_empty = 1'b1;
        end
    endtask

    task automatic push(input axi4s_dp_bus_t w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh_head();
        $display("push id=%h sot=%0d eot=%0d", w.tdata, w.tuser[0], w.tuser[1]);
    endtask

    // Drive point: just after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Sample point: just after the falling edge (after the monitor ran).
    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    // Monitor: record pops and compare every accepted beat with the scoreboard.
    always @(negedge clk) begin
        axi4s_dp_bus_t w;
        pop_pend = ob_fifo_rd;
        if (ob_fifo_rd) pop_cnt++;
        if (ob_out_tvalid && ob_out_tready) begin
            acc_cnt++;
            check("sb_avail", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("sb_word", ob_out, w);
                $display("egress data=%h tuser=%h", ob_out.tdata, ob_out.tuser);
            end
        end
    end

    // FIFO model: the popped head is removed after the edge that consumed it.
    always @(posedge clk) begin
        #1;
        if (pop_pend && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            refresh_head();
        end
        pop_pend = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int a0;
        int n;

        rst_n         = 1'b0;
        ob_out_tready = 1'b0;
        ob_hold       = 1'b0;
        ob_err_clr    = 1'b0;
        refresh_head();
        repeat (3) step();

        // ---- reset state ----
        samp();
        check("rst_tvalid", ob_out_tvalid, 0);
        check("rst_out", ob_out, 0);
        check("rst_rd", ob_fifo_rd, 0);
        check("rst_sot_err", ob_sot_err, 0);
        check("rst_nosot_err", ob_nosot_err, 0);
        check("rst_frame_cnt", ob_frame_cnt, 0);
        check("rst_beat_cnt", ob_beat_cnt, 0);

        // ---- 3-beat frame, 1-cycle latency, full throughput ----
        step();
        rst_n = 1'b1;
        ob_out_tready = 1'b1;
        push(mk(1, 1'b1, 1'b0));
        push(mk(2, 1'b0, 1'b0));
        push(mk(3, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++) begin
            samp();
            check("f3_rd", ob_fifo_rd, (i < 3));
            check("f3_tvalid", ob_out_tvalid, (i > 0));
        end
        samp();
        check("f3_drained", exp_q.size(), 0);
`ifdef CR_OSF_OB_STATS_EN
        check("f3_frame_cnt", ob_frame_cnt, 1);
        check("f3_beat_cnt", ob_beat_cnt, 3);
`else
        check("f3_frame_cnt", ob_frame_cnt, 0);
        check("f3_beat_cnt", ob_beat_cnt, 0);
`endif
        check("f3_no_err", {ob_sot_err, ob_nosot_err}, 0);

        // ---- back-pressure: 8 beats, tready low for 5 cycles ----
        step();
        ob_out_tready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) push(mk(10 + i, (i == 0), (i == 7)));
        repeat (5) samp();
        check("bp_pops", pop_cnt - p0, 2);
        check("bp_rd_low", ob_fifo_rd, 0);
        check("bp_tvalid", ob_out_tvalid, 1);
        step();
        ob_out_tready = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            samp();
            check("bp_no_gap", ob_out_tvalid, 1);
        end
        check("bp_accepts", acc_cnt - a0, 8);
        samp();
        check("bp_empty_tvalid", ob_out_tvalid, 0);
        check("bp_drained", exp_q.size(), 0);

        // ---- hold asserted mid-frame ----
        step();
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) push(mk(20 + i, (i == 0), (i == 3)));
        push(mk(24, 1'b1, 1'b0));
        push(mk(25, 1'b0, 1'b1));
        n = 0;
        while ((pop_cnt - p0) < 2 && n < 20) begin
            samp();
            n++;
        end
        check("hold_reach_beat2", (pop_cnt - p0) >= 2, 1);
        step();
        ob_hold = 1'b1;
        repeat (8) samp();
        check("hold_pops", pop_cnt - p0, 4);
        check("hold_rd_low", ob_fifo_rd, 0);
        check("hold_fifo_left", fifo_q.size(), 2);
        check("hold_tvalid", ob_out_tvalid, 0);
        step();
        ob_hold = 1'b0;
        repeat (5) samp();
        check("hold_release_pops", pop_cnt - p0, 6);
        check("hold_drained", exp_q.size(), 0);

        // ---- framing errors ----
        step();
        push(mk(30, 1'b1, 1'b0));
        push(mk(31, 1'b1, 1'b0));
        push(mk(32, 1'b0, 1'b1));
        repeat (6) samp();
        check("err_sot_set", ob_sot_err, 1);
        check("err_nosot_clean", ob_nosot_err, 0);
        repeat (3) samp();
        check("err_sot_sticky", ob_sot_err, 1);
        step();
        ob_err_clr = 1'b1;
        step();
        ob_err_clr = 1'b0;
        samp();
        check("err_sot_cleared", ob_sot_err, 0);
        step();
        push(mk(33, 1'b1, 1'b1));
        push(mk(34, 1'b1, 1'b1));
        repeat (5) samp();
        check("single_beat_sot", ob_sot_err, 0);
        check("single_beat_nosot", ob_nosot_err, 0);
        step();
        push(mk(35, 1'b0, 1'b1));
        repeat (4) samp();
        check("err_nosot_set", ob_nosot_err, 1);
        step();
        ob_err_clr = 1'b1;
        step();
        ob_err_clr = 1'b0;
        samp();
        check("err_nosot_cleared", ob_nosot_err, 0);
        step();
        push(mk(36, 1'b0, 1'b1));
        ob_err_clr = 1'b1;
        step();
        ob_err_clr = 1'b0;
        samp();
        check("err_set_beats_clr", ob_nosot_err, 1);
        step();
        ob_err_clr = 1'b1;
        step();
        ob_err_clr = 1'b0;
        repeat (3) samp();
        check("err_all_clear", {ob_sot_err, ob_nosot_err}, 0);
        check("err_drained", exp_q.size(), 0);

`ifdef CR_OSF_OB_STATS_EN
        // ---- beat counter wrap ----
        step();
        force dut.beat_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.beat_cnt_q;
        push(mk(50, 1'b1, 1'b0));
        push(mk(51, 1'b0, 1'b1));
        repeat (3) samp();
        check("wrap_beat0", ob_beat_cnt, 32'h0000_0000);
        samp();
        check("wrap_beat1", ob_beat_cnt, 32'h0000_0001);
`else
        check("nostats_frame_cnt", ob_frame_cnt, 0);
        check("nostats_beat_cnt", ob_beat_cnt, 0);
`endif

        // ---- reset mid-frame with a full skid buffer ----
        step();
        ob_out_tready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk(40 + i, (i == 0), (i == 4)));
        repeat (4) samp();
        check("mrst_full_tvalid", ob_out_tvalid, 1);
        check("mrst_full_rd", ob_fifo_rd, 0);
        step();
        rst_n = 1'b0;
        p0 = pop_cnt;
        samp();
        check("mrst_rd_in_reset", ob_fifo_rd, 0);
        samp();
        check("mrst_tvalid_after", ob_out_tvalid, 0);
        check("mrst_rd_after", ob_fifo_rd, 0);
        check("mrst_no_pop", pop_cnt - p0, 0);
        fifo_q.delete();
        exp_q.delete();
        refresh_head();
        step();
        rst_n = 1'b1;
        ob_out_tready = 1'b1;
        samp();
        check("mrst_released_tvalid", ob_out_tvalid, 0);
        check("mrst_err_reset", ob_nosot_err, 0);
        step();
        push(mk(45, 1'b0, 1'b1));
        repeat (4) samp();
        check("mrst_nosot_after", ob_nosot_err, 1);
        check("mrst_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
